task_admit_scheduler: RTL and testbench
=======================================

Name: task_admit_scheduler

Overview:
- Feeds the per-RPU TaskFIFOs ahead of the RPU task distributor.
- Arbitrates push/pop/push-pop task requests from NREQ requesters, one grant per cycle, round-robin.
- Packs each granted request into the TaskFIFO entry format and writes it to one of LEVEL TaskFIFOs, chosen round-robin among non-full FIFOs.
- Keeps a per-tree occupancy model: pops to empty trees and pushes to full trees are filtered out before they reach the tree pipeline.

Parameters:
- PTW, 16, payload data width
- MTW, 16, metadata width
- PLW, 8, packet length width
- LEVEL, 4, number of TaskFIFOs / RPUs
- TREE_NUM, 4, number of trees
- NREQ, 4, number of requesters
- CNTW, 10, per-tree occupancy counter width; tree capacity is 2^CNTW-1
- Derived: DW = PTW+MTW+PLW; TB = clog2(TREE_NUM); EW = DW+2*TB+2

Ports:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_enable  in  1  grants allowed when high
- i_req_valid  in  NREQ  request valid per requester
- o_req_ready  out  NREQ  one-hot (or zero) accept strobe
- i_req_push  in  NREQ  request carries a push
- i_req_pop  in  NREQ  request carries a pop
- i_req_push_tree  in  TB x NREQ  push target tree
- i_req_pop_tree  in  TB x NREQ  pop target tree
- i_req_data  in  DW x NREQ  push payload
- i_TaskFIFO_full  in  LEVEL  FIFO cannot accept a write
- o_TaskFIFO_wr  out  LEVEL  one-hot write strobe
- o_TaskFIFO_data  out  EW x LEVEL  entry {push, pop, push_tree, pop_tree, data}
- o_tree_cnt  out  CNTW x TREE_NUM  modelled occupancy per tree
- o_err_pop_empty  out  1  pulse: pop part dropped, tree empty
- o_err_push_full  out  1  pulse: push part dropped, tree full
- o_err_tree  out  TB  tree id of the dropped part (push tree if both errors fire)

Behaviour:
Reset values:
- All outputs, occupancy counters and the requester/target pointers (rr_ptr, tgt_ptr) reset to 0.
- Reset mid-operation aborts any pending write; the registered write strobe is cleared immediately.

Arbitration (combinational, cycle t):
- Requester: first valid index at or after rr_ptr, circular.
- Target: first FIFO k, circular from tgt_ptr, with i_TaskFIFO_full[k]=0 and k not written in cycle t (no back-to-back writes to one FIFO).
- Grant = i_enable & any valid & target exists. On grant, o_req_ready[r]=1 in cycle t.
- rr_ptr <= (r+1) mod NREQ; tgt_ptr <= (k+1) mod LEVEL. No grant leaves both pointers unchanged.

Admission per granted request, using counters at cycle t:
- Pop part valid iff cnt[pop_tree] > 0, or push_tree == pop_tree and the push part is valid.
- Push part valid iff cnt[push_tree] < 2^CNTW-1, or push+pop target the same tree and that pop is valid.
- An invalid part is dropped and raises its error pulse in t+1 with o_err_tree.
- Remaining parts form the entry. If none remain (both dropped, or neither bit set), the request is still consumed but no write occurs. Neither-bit requests raise no error.

Entry packing:
- bit EW-1 = push, EW-2 = pop; then push_tree; then pop_tree; then data.
- Push_tree and data are zeroed when there is no push; pop_tree is zeroed when there is no pop.

Write timing:
- o_TaskFIFO_wr[k] and o_TaskFIFO_data[k] are registered and asserted in t+1 for exactly one cycle.
- Non-written FIFOs hold their previous data.

Counter update (t+1):
- Push-only: +1. Pop-only: -1.
- Push+pop, same tree: unchanged.
- Push+pop, different trees: +1 on push tree, -1 on pop tree.
- Counters never wrap; this is guaranteed by the admission rules.

Other rules:
- i_req_* fields must stay stable while valid and not ready.
- i_enable low: no grants; in-flight write still completes.

Test Plan:
- Reset, then push-only from req0 to tree2, data 0x1234_5678_9A, all FIFOs empty -> ready[0] at t; wr[0] at t+1; entry {1,0,2,0,data}; cnt[2]=1.
- All 4 requesters valid continuously, pushes to tree 0 -> grants 0,1,2,3,0 on consecutive cycles; writes to FIFOs 0,1,2,3,0; cnt[0]=5 after 5 grants.
- Pop-only to tree 1 with cnt[1]=0 -> ready pulses, no write, o_err_pop_empty=1 and o_err_tree=1 at t+1, cnt unchanged.
- Push tree3 + pop tree3 with cnt[3]=0 -> entry {1,1,3,3,data}, cnt[3] stays 0, no error.
- i_TaskFIFO_full=4'b0111 with repeated requests -> writes only to FIFO 3, every other cycle (no back-to-back); full=4'b1111 -> no ready.
- cnt[0]=1023 (CNTW=10), push tree0 + pop tree1 with cnt[1]=5 -> push dropped, o_err_push_full, entry {0,1,0,1,0}, cnt[1]=4. Assert reset during the resulting write -> wr cleared at once.

Source files
------------

// File: rtl/task_admit_scheduler.sv
// Task admission front-end: round-robin arbitration of push/pop task requests,
// per-tree occupancy filtering, and round-robin writes into the per-RPU TaskFIFOs.
module task_admit_scheduler #(
  parameter int unsigned PTW      = 16,
  parameter int unsigned MTW      = 16,
  parameter int unsigned PLW      = 8,
  parameter int unsigned LEVEL    = 4,
  parameter int unsigned TREE_NUM = 4,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CNTW     = 10,
  localparam int unsigned DW = PTW + MTW + PLW,
  localparam int unsigned TB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  localparam int unsigned EW = DW + 2*TB + 2
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_enable,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ-1:0]          i_req_push,
  input  logic [NREQ-1:0]          i_req_pop,
  input  logic [TB*NREQ-1:0]       i_req_push_tree,
  input  logic [TB*NREQ-1:0]       i_req_pop_tree,
  input  logic [DW*NREQ-1:0]       i_req_data,
  input  logic [LEVEL-1:0]         i_TaskFIFO_full,
  output logic [LEVEL-1:0]         o_TaskFIFO_wr,
  output logic [EW*LEVEL-1:0]      o_TaskFIFO_data,
  output logic [CNTW*TREE_NUM-1:0] o_tree_cnt,
  output logic                     o_err_pop_empty,
  output logic                     o_err_push_full,
  output logic [TB-1:0]            o_err_tree
);

  localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned LW = (LEVEL > 1) ? $clog2(LEVEL) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [RW-1:0]   rr_ptr;
  logic [LW-1:0]   tgt_ptr;
  logic [CNTW-1:0] cnt_q  [TREE_NUM];
  logic [EW-1:0]   data_q [LEVEL];

  logic [TB-1:0]   push_tree_a [NREQ];
  logic [TB-1:0]   pop_tree_a  [NREQ];
  logic [DW-1:0]   data_a      [NREQ];

  logic            req_found;
  logic [RW-1:0]   req_sel;
  logic            tgt_found;
  logic [LW-1:0]   tgt_sel;
  logic            grant;

  logic            sel_push;
  logic            sel_pop;
  logic [TB-1:0]   sel_pt;
  logic [TB-1:0]   sel_qt;
  logic [DW-1:0]   sel_data;
  logic            same_tree;
  logic            push_ok;
  logic            pop_ok;
  logic            do_write;
  logic [EW-1:0]   entry;
  logic [TREE_NUM-1:0] cnt_inc;
  logic [TREE_NUM-1:0] cnt_dec;

  function automatic logic [RW-1:0] req_at(input logic [RW-1:0] base, input int unsigned off);
    return RW'((32'(base) + off) % NREQ);
  endfunction

  function automatic logic [LW-1:0] fifo_at(input logic [LW-1:0] base, input int unsigned off);
    return LW'((32'(base) + off) % LEVEL);
  endfunction

  // Unpack the flat per-requester fields
  always_comb begin
    for (int unsigned r = 0; r < NREQ; r++) begin
      push_tree_a[r] = i_req_push_tree[r*TB +: TB];
      pop_tree_a[r]  = i_req_pop_tree[r*TB +: TB];
      data_a[r]      = i_req_data[r*DW +: DW];
    end
  end

  // Circular search for the next requester and the next writable FIFO
  always_comb begin
    req_found = 1'b0;
    req_sel   = '0;
    tgt_found = 1'b0;
    tgt_sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!req_found && i_req_valid[req_at(rr_ptr, i)]) begin
        req_found = 1'b1;
        req_sel   = req_at(rr_ptr, i);
      end
    end
    // a FIFO being written this cycle is skipped to avoid back-to-back writes
    for (int unsigned i = 0; i < LEVEL; i++) begin
      if (!tgt_found && !i_TaskFIFO_full[fifo_at(tgt_ptr, i)] && !o_TaskFIFO_wr[fifo_at(tgt_ptr, i)]) begin
        tgt_found = 1'b1;
        tgt_sel   = fifo_at(tgt_ptr, i);
      end
    end
  end

  assign grant = i_enable & req_found & tgt_found;

  // Combinational accept strobe for the granted requester
  always_comb begin
    o_req_ready = '0;
    if (grant) o_req_ready[req_sel] = 1'b1;
  end

  // Admission against the occupancy model and entry packing
  always_comb begin
    sel_push  = i_req_push[req_sel];
    sel_pop   = i_req_pop[req_sel];
    sel_pt    = push_tree_a[req_sel];
    sel_qt    = pop_tree_a[req_sel];
    sel_data  = data_a[req_sel];
    same_tree = (sel_pt == sel_qt);
    // a push and pop on the same tree cancel, so each validates the other
    push_ok   = sel_push & ((cnt_q[sel_pt] != CNT_MAX) | (same_tree & sel_pop));
    pop_ok    = sel_pop  & ((cnt_q[sel_qt] != '0)      | (same_tree & sel_push));
    do_write  = grant & (push_ok | pop_ok);
    entry     = {push_ok, pop_ok,
                 push_ok ? sel_pt : TB'(0),
                 pop_ok  ? sel_qt : TB'(0),
                 push_ok ? sel_data : DW'(0)};
    for (int unsigned t = 0; t < TREE_NUM; t++) begin
      cnt_inc[t] = grant & push_ok & (sel_pt == TB'(t));
      cnt_dec[t] = grant & pop_ok  & (sel_qt == TB'(t));
    end
  end

  // Round-robin pointers advance past the granted requester and FIFO
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_ptr  <= '0;
      tgt_ptr <= '0;
    end else if (grant) begin
      rr_ptr  <= req_at(req_sel, 1);
      tgt_ptr <= fifo_at(tgt_sel, 1);
    end
  end

  // Registered one-cycle FIFO write; unwritten FIFOs keep their data
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_TaskFIFO_wr <= '0;
      for (int unsigned k = 0; k < LEVEL; k++) data_q[k] <= '0;
    end else begin
      o_TaskFIFO_wr <= '0;
      if (do_write) begin
        o_TaskFIFO_wr[tgt_sel] <= 1'b1;
        data_q[tgt_sel]        <= entry;
      end
    end
  end

  // Error pulses for dropped request parts
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_err_pop_empty <= 1'b0;
      o_err_push_full <= 1'b0;
      o_err_tree      <= '0;
    end else begin
      o_err_push_full <= grant & sel_push & ~push_ok;
      o_err_pop_empty <= grant & sel_pop & ~pop_ok;
      if (grant & sel_push & ~push_ok)    o_err_tree <= sel_pt;
      else if (grant & sel_pop & ~pop_ok) o_err_tree <= sel_qt;
      else                                o_err_tree <= '0;
    end
  end

  // Per-tree occupancy counters
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int unsigned t = 0; t < TREE_NUM; t++) cnt_q[t] <= '0;
    end else begin
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
        if (cnt_inc[t] && !cnt_dec[t])      cnt_q[t] <= cnt_q[t] + CNTW'(1);
        else if (cnt_dec[t] && !cnt_inc[t]) cnt_q[t] <= cnt_q[t] - CNTW'(1);
      end
    end
  end

  // Flatten FIFO data and counters onto the output buses
  always_comb begin
    for (int unsigned k = 0; k < LEVEL; k++) o_TaskFIFO_data[k*EW +: EW] = data_q[k];
    for (int unsigned t = 0; t < TREE_NUM; t++) o_tree_cnt[t*CNTW +: CNTW] = cnt_q[t];
  end

endmodule

// File: tb/tb_task_admit_scheduler.sv
// Bench for task_admit_scheduler: directed scenarios plus random traffic against a reference model.
module tb_task_admit_scheduler;

  localparam int PTW = 16, MTW = 16, PLW = 8;
  localparam int LEVEL = 4, TREE_NUM = 4, NREQ = 4, CNTW = 10;
  localparam int DW = PTW + MTW + PLW;
  localparam int TB = 2;
  localparam int EW = DW + 2*TB + 2;
  localparam int RW = 2;
  localparam int LW = 2;
  localparam int MAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     en;
  logic [NREQ-1:0]          req_valid, req_push, req_pop;
  logic [TB-1:0]            pt_a [NREQ];
  logic [TB-1:0]            qt_a [NREQ];
  logic [DW-1:0]            d_a  [NREQ];
  logic [TB*NREQ-1:0]       req_push_tree, req_pop_tree;
  logic [DW*NREQ-1:0]       req_data;
  logic [LEVEL-1:0]         full;
  logic [NREQ-1:0]          ready;
  logic [LEVEL-1:0]         wr;
  logic [EW*LEVEL-1:0]      fifo_data;
  logic [CNTW*TREE_NUM-1:0] tree_cnt;
  logic                     err_pop, err_push;
  logic [TB-1:0]            err_tree;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_push_tree[i*TB +: TB] = pt_a[i];
      req_pop_tree[i*TB +: TB]  = qt_a[i];
      req_data[i*DW +: DW]      = d_a[i];
    end
  end

  task_admit_scheduler #(
    .PTW(PTW), .MTW(MTW), .PLW(PLW), .LEVEL(LEVEL),
    .TREE_NUM(TREE_NUM), .NREQ(NREQ), .CNTW(CNTW)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_enable(en),
    .i_req_valid(req_valid), .o_req_ready(ready),
    .i_req_push(req_push), .i_req_pop(req_pop),
    .i_req_push_tree(req_push_tree), .i_req_pop_tree(req_pop_tree),
    .i_req_data(req_data), .i_TaskFIFO_full(full),
    .o_TaskFIFO_wr(wr), .o_TaskFIFO_data(fifo_data), .o_tree_cnt(tree_cnt),
    .o_err_pop_empty(err_pop), .o_err_push_full(err_push), .o_err_tree(err_tree)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int              rr_m, tgt_m;
  logic [LEVEL-1:0] last_wr_m;
  int              cnt_m [TREE_NUM];
  logic [EW-1:0]   fifo_m [LEVEL];
  logic [NREQ-1:0] exp_ready;
  logic [LEVEL-1:0] exp_wr;
  logic            exp_err_pop, exp_err_push;
  logic [TB-1:0]   exp_err_tree;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CNTW*TREE_NUM-1:0] pack_cnt();
    logic [CNTW*TREE_NUM-1:0] p;
    for (int t = 0; t < TREE_NUM; t++) p[t*CNTW +: CNTW] = CNTW'(cnt_m[t]);
    return p;
  endfunction

  function automatic logic [EW*LEVEL-1:0] pack_fifo();
    logic [EW*LEVEL-1:0] p;
    for (int k = 0; k < LEVEL; k++) p[k*EW +: EW] = fifo_m[k];
    return p;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    rr_m = 0; tgt_m = 0; last_wr_m = '0;
    for (int t = 0; t < TREE_NUM; t++) cnt_m[t] = 0;
    for (int k = 0; k < LEVEL; k++) fifo_m[k] = '0;
    exp_ready = '0; exp_wr = '0; exp_err_pop = 1'b0; exp_err_push = 1'b0; exp_err_tree = '0;
  endtask

  // Decide this cycle's grant from the rules and predict next-cycle outputs
  task automatic model_step();
    logic [RW-1:0] ri, r;
    logic [LW-1:0] ki, k;
    bit rf, kf, push, pop, same, push_alone, pop_alone, push_ok, pop_ok;
    logic [TB-1:0] pt, qt;
    logic [DW-1:0] d;
    rf = 0; kf = 0; r = '0; k = '0;
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        ri = RW'((rr_m + i) % NREQ);
        if (!rf && req_valid[ri]) begin rf = 1; r = ri; end
      end
    end
    for (int i = 0; i < LEVEL; i++) begin
      ki = LW'((tgt_m + i) % LEVEL);
      if (!kf && !full[ki] && !last_wr_m[ki]) begin kf = 1; k = ki; end
    end
    exp_ready = '0;
    if (rf && kf) exp_ready[r] = 1'b1;
    check("req_ready", 256'(ready), 256'(exp_ready));
    exp_wr = '0; exp_err_pop = 1'b0; exp_err_push = 1'b0; exp_err_tree = '0; last_wr_m = '0;
    if (rf && kf) begin
      rr_m  = (int'(r) + 1) % NREQ;
      tgt_m = (int'(k) + 1) % LEVEL;
      push = req_push[r]; pop = req_pop[r]; pt = pt_a[r]; qt = qt_a[r]; d = d_a[r];
      same = (pt == qt);
      push_alone = push && (cnt_m[pt] < MAX);
      pop_alone  = pop && (cnt_m[qt] > 0);
      push_ok = push && (push_alone || (same && pop_alone));
      pop_ok  = pop && (pop_alone || (same && push_alone));
      exp_err_push = push && !push_ok;
      exp_err_pop  = pop && !pop_ok;
      exp_err_tree = exp_err_push ? pt : qt;
      if (push_ok || pop_ok) begin
        exp_wr[k] = 1'b1;
        last_wr_m[k] = 1'b1;
        fifo_m[k] = {push_ok, pop_ok, push_ok ? pt : TB'(0), pop_ok ? qt : TB'(0), push_ok ? d : DW'(0)};
      end
      if (push_ok) cnt_m[pt] = cnt_m[pt] + 1;
      if (pop_ok)  cnt_m[qt] = cnt_m[qt] - 1;
    end
  endtask

  task automatic check_outputs();
    check("fifo_wr", 256'(wr), 256'(exp_wr));
    check("fifo_data", 256'(fifo_data), 256'(pack_fifo()));
    check("tree_cnt", 256'(tree_cnt), 256'(pack_cnt()));
    check("err_pop_empty", 256'(err_pop), 256'(exp_err_pop));
    check("err_push_full", 256'(err_push), 256'(exp_err_push));
    if (exp_err_pop || exp_err_push) check("err_tree", 256'(err_tree), 256'(exp_err_tree));
  endtask

  // Inputs are driven at a negedge before calling; outputs checked at the next negedge
  task automatic step();
    #1;
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_req(input int r, input bit push, input bit pop, input int pt, input int qt,
                         input logic [DW-1:0] d);
    logic [RW-1:0] ri;
    ri = RW'(r);
    req_valid[ri] = 1'b1; req_push[ri] = push; req_pop[ri] = pop;
    pt_a[ri] = TB'(pt); qt_a[ri] = TB'(qt); d_a[ri] = d;
  endtask

  task automatic idle();
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(); full = '0; en = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] ri;
    logic [DW-1:0] dx;
    int w3;
    rst_n = 1'b0; en = 1'b1; full = '0;
    req_valid = '0; req_push = '0; req_pop = '0;
    for (int i = 0; i < NREQ; i++) begin pt_a[i] = '0; qt_a[i] = '0; d_a[i] = '0; end
    do_reset();

    // Reset state
    check_outputs();
    check("rst_ready", 256'(ready), 256'(0));

    // Push-only from req0 to tree 2
    set_req(0, 1, 0, 2, 0, 40'h12_3456_789A);
    #1 check("p1_ready", 256'(ready), 256'(4'b0001));
    step();
    idle();
    check("p1_wr", 256'(wr), 256'(4'b0001));
    check("p1_entry", 256'(fifo_data[0 +: EW]), 256'({1'b1, 1'b0, 2'd2, 2'd0, 40'h12_3456_789A}));
    check("p1_cnt2", 256'(tree_cnt[2*CNTW +: CNTW]), 256'(1));
    step();

    // All requesters continuously pushing to tree 0
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 0, rnd_data());
    for (int c = 0; c < 5; c++) begin
      #1 check("rr_grant", 256'(ready), 256'(4'b0001 << (c % 4)));
      step();
      check("rr_write", 256'(wr), 256'(4'b0001 << (c % 4)));
    end
    idle();
    check("rr_cnt0", 256'(tree_cnt[0 +: CNTW]), 256'(5));
    step();

    // Pop-only to empty tree 1
    set_req(2, 0, 1, 0, 1, rnd_data());
    step();
    idle();
    check("pe_err", 256'(err_pop), 256'(1));
    check("pe_tree", 256'(err_tree), 256'(1));
    check("pe_nowr", 256'(wr), 256'(0));
    step();

    // Push and pop on tree 3 while it is empty
    dx = rnd_data();
    set_req(1, 1, 1, 3, 3, dx);
    step();
    idle();
    check("pp_entry", 256'(fifo_data[2*EW +: EW]), 256'({1'b1, 1'b1, 2'd3, 2'd3, dx}));
    check("pp_cnt3", 256'(tree_cnt[3*CNTW +: CNTW]), 256'(0));
    check("pp_noerr", 256'({err_pop, err_push}), 256'(0));
    step();

    // Only FIFO 3 writable: no back-to-back writes
    full = 4'b0111;
    set_req(1, 1, 0, 2, 0, rnd_data());
    w3 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (wr === 4'b1000) w3++;
    end
    check("f3_writes", 256'(w3), 256'(3));
    full = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1 check("full_noready", 256'(ready), 256'(0));
      step();
    end
    idle(); full = '0;
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        ri = RW'(i);
        if (exp_ready[ri]) req_valid[ri] = 1'b0;
        if (!req_valid[ri] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, TREE_NUM-1)), int'($urandom_range(0, TREE_NUM-1)), rnd_data());
      end
      full = ($urandom_range(0, 3) == 0) ? LEVEL'($urandom()) : '0;
      en = ($urandom_range(0, 9) != 0);
      step();
    end
    idle(); full = '0; en = 1'b1;
    step();

    // Fill tree 0 to capacity and tree 1 to five
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, 0, 0, rnd_data());
    for (int n = 0; n < 1500 && cnt_m[0] != MAX; n++) step();
    idle();
    check("fill_cnt0", 256'(tree_cnt[0 +: CNTW]), 256'(MAX));
    set_req(0, 1, 0, 1, 0, rnd_data());
    for (int n = 0; n < 20 && cnt_m[1] != 5; n++) step();
    idle();
    check("fill_cnt1", 256'(tree_cnt[1*CNTW +: CNTW]), 256'(5));
    step();

    // Push to a full tree is dropped
    set_req(2, 1, 0, 0, 0, rnd_data());
    step();
    idle();
    check("pf_err", 256'(err_push), 256'(1));
    check("pf_nowr", 256'(wr), 256'(0));
    step();

    // Push to full tree 0 with pop from tree 1: only the pop survives
    set_req(3, 1, 1, 0, 1, rnd_data());
    step();
    idle();
    check("mix_err", 256'({err_push, err_pop, err_tree}), 256'({1'b1, 1'b0, 2'd0}));
    for (int k = 0; k < LEVEL; k++)
      if (exp_wr[LW'(k)]) check("mix_entry", 256'(fifo_data[k*EW +: EW]), 256'({1'b0, 1'b1, 2'd0, 2'd1, 40'd0}));
    check("mix_cnt1", 256'(tree_cnt[1*CNTW +: CNTW]), 256'(4));
    check("mix_wr_any", 256'(wr != '0), 256'(1));

    // Reset during the write clears the strobe immediately
    rst_n = 1'b0;
    #1;
    check("rst_wr", 256'(wr), 256'(0));
    check("rst_cnt", 256'(tree_cnt), 256'(0));
    check("rst_data", 256'(fifo_data), 256'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
